// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply loop sequencer: FSM state
// encoding, default sizing and the address-width sanity check.
package matmul_pkg;

    localparam int DEF_IDX_W  = 4;
    localparam int DEF_N_MAX  = 8;
    localparam int DEF_ADDR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    // True when an ADDR_W-bit address can reach the last element of an
    // n_max x n_max matrix stored with row pitch n_max.
    function automatic bit addr_w_ok(input int n_max, input int addr_w);
        return (n_max * n_max - 1) < (1 << addr_w);
    endfunction

endpackage

// File: rtl/loop_counter.sv
// One loop index of the i/j/k nest: counts 0..last_i on inc_i, wraps to 0
// and raises wrap_o in the same cycle as the wrapping increment so the next
// outer counter can be chained directly from it.
module loop_counter #(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [IDX_W-1:0] idx_o,
    output logic [IDX_W-1:0] idx_d_o,
    output logic             wrap_o
);

    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic             at_last;

    assign at_last = (idx_q == last_i);

    // Next index: clear wins, otherwise step or wrap on increment.
    always_comb begin
        // NOTE: default assignment first so every path drives idx_d and no latch is inferred.
        idx_d = idx_q;
        if (clr_i) begin
            idx_d = '0;
        end else if (inc_i) begin
            idx_d = at_last ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Index register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment so all registers update together at the edge.
        if (!rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx_o   = idx_q;
    assign idx_d_o = idx_d;
    assign wrap_o  = inc_i && at_last && !clr_i;

endmodule

// File: rtl/matmul_loop_sequencer.sv
// Runtime-bounded, stallable i/j/k sequencer for C = A*B. Issues one MAC
// operation per op_valid/op_ready transfer with registered indices,
// incrementally updated A/B/C addresses and accumulator controls.
// Optional build macro MATMUL_SEQ_PERF_EN adds perf_cycles/perf_stalls.
module matmul_loop_sequencer
    import matmul_pkg::*;
#(
    parameter int IDX_W  = DEF_IDX_W,
    parameter int N_MAX  = DEF_N_MAX,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IDX_W-1:0]  dim_n,
    output logic              busy,
    output logic              done,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [IDX_W-1:0]  idx_i,
    output logic [IDX_W-1:0]  idx_j,
    output logic [IDX_W-1:0]  idx_k,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic [ADDR_W-1:0] addr_c,
    output logic              acc_clr,
    output logic              acc_wr
`ifdef MATMUL_SEQ_PERF_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_stalls
`endif
);

    if (!addr_w_ok(N_MAX, ADDR_W)) begin : g_addr_w_check
        $error("ADDR_W too small to address an N_MAX x N_MAX matrix");
    end

    localparam logic [IDX_W-1:0]  N_MAX_IDX = IDX_W'(N_MAX);
    localparam logic [ADDR_W-1:0] PITCH     = ADDR_W'(N_MAX);

    state_e             state_q;
    state_e             state_d;
    logic [IDX_W-1:0]   n_q;
    logic               busy_q;
    logic               done_q;
    logic               op_valid_q;
    logic               acc_clr_q;
    logic               acc_wr_q;
    logic [ADDR_W-1:0]  addr_a_q;
    logic [ADDR_W-1:0]  addr_b_q;
    logic [ADDR_W-1:0]  addr_c_q;
    logic [ADDR_W-1:0]  row_base_q;

    logic               accept;
    logic               transfer;
    logic               run_d;
    logic [IDX_W-1:0]   n_clamp;
    logic [IDX_W-1:0]   bound_d;
    logic [IDX_W-1:0]   last_idx;
    logic [ADDR_W-1:0]  next_row;

    logic [IDX_W-1:0]   k_q, j_q, i_q;
    logic [IDX_W-1:0]   k_d, j_d, i_next_unused;
    logic               k_wrap, j_wrap, i_wrap;

    assign accept   = (state_q == ST_IDLE) && start;
    assign transfer = op_valid_q && op_ready;
    assign n_clamp  = (dim_n > N_MAX_IDX) ? N_MAX_IDX : dim_n;
    assign bound_d  = accept ? n_clamp : n_q;
    assign last_idx = n_q - IDX_W'(1);
    assign next_row = row_base_q + PITCH;

    // k advances on every transfer; j and i advance on the wrap of the next-inner index.
    loop_counter #(.IDX_W(IDX_W)) u_cnt_k (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (accept),
        .inc_i   (transfer),
        .last_i  (last_idx),
        .idx_o   (k_q),
        .idx_d_o (k_d),
        .wrap_o  (k_wrap)
    );

    loop_counter #(.IDX_W(IDX_W)) u_cnt_j (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (accept),
        .inc_i   (k_wrap),
        .last_i  (last_idx),
        .idx_o   (j_q),
        .idx_d_o (j_d),
        .wrap_o  (j_wrap)
    );

    loop_counter #(.IDX_W(IDX_W)) u_cnt_i (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (accept),
        .inc_i   (j_wrap),
        .last_i  (last_idx),
        .idx_o   (i_q),
        .idx_d_o (i_next_unused),
        .wrap_o  (i_wrap)
    );

    // Next state: the wrap of i marks the transfer of the final (n-1,n-1,n-1) operation.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = (n_clamp == '0) ? ST_FIN : ST_RUN;
            ST_RUN:  if (i_wrap) state_d = ST_FIN;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign run_d = (state_d == ST_RUN);

    // Control FSM with registered handshake, status and accumulator outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            n_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            op_valid_q <= 1'b0;
            acc_clr_q  <= 1'b0;
            acc_wr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= (state_d != ST_IDLE);
            done_q     <= (state_d == ST_FIN);
            op_valid_q <= run_d;
            if (accept) begin
                n_q <= n_clamp;
            end
            acc_clr_q  <= run_d && (k_d == '0);
            acc_wr_q   <= run_d && (k_d == bound_d - IDX_W'(1));
        end
    end

    // Addresses follow the indices by adding 1 or the row pitch; every index
    // wraps to 0 on the final transfer, so the addresses return to 0 with them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            addr_c_q   <= '0;
            row_base_q <= '0;
        end else if (accept || i_wrap) begin
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            addr_c_q   <= '0;
            row_base_q <= '0;
        end else if (j_wrap) begin
            row_base_q <= next_row;
            addr_a_q   <= next_row;
            addr_b_q   <= '0;
            addr_c_q   <= next_row;
        end else if (k_wrap) begin
            addr_a_q   <= row_base_q;
            addr_b_q   <= ADDR_W'(j_d);
            addr_c_q   <= addr_c_q + ADDR_W'(1);
        end else if (transfer) begin
            addr_a_q   <= addr_a_q + ADDR_W'(1);
            addr_b_q   <= addr_b_q + PITCH;
        end
    end

`ifdef MATMUL_SEQ_PERF_EN
    logic [31:0] perf_cycles_q;
    logic [31:0] perf_stalls_q;

    // Saturating run/stall counters, cleared when a run is accepted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else if (accept) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else if (state_q == ST_RUN) begin
            if (perf_cycles_q != '1) begin
                perf_cycles_q <= perf_cycles_q + 32'd1;
            end
            if (!op_ready && (perf_stalls_q != '1)) begin
                perf_stalls_q <= perf_stalls_q + 32'd1;
            end
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stalls = perf_stalls_q;
`endif

    assign busy     = busy_q;
    assign done     = done_q;
    assign op_valid = op_valid_q;
    assign idx_i    = i_q;
    assign idx_j    = j_q;
    assign idx_k    = k_q;
    assign addr_a   = addr_a_q;
    assign addr_b   = addr_b_q;
    assign addr_c   = addr_c_q;
    assign acc_clr  = acc_clr_q;
    assign acc_wr   = acc_wr_q;

endmodule

// File: tb/tb_matmul_loop_sequencer.sv
// Self-checking bench for matmul_loop_sequencer. The expected operation
// stream is derived from the triple-loop definition: operation number p of
// an n-run has i = p/(n*n), j = (p/n)%n, k = p%n.
module tb_matmul_loop_sequencer;

    localparam int IDX_W  = 4;
    localparam int N_MAX  = 8;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [IDX_W-1:0]  dim_n;
    logic              busy, done, op_valid;
    logic              op_ready;
    logic [IDX_W-1:0]  idx_i, idx_j, idx_k;
    logic [ADDR_W-1:0] addr_a, addr_b, addr_c;
    logic              acc_clr, acc_wr;
`ifdef MATMUL_SEQ_PERF_EN
    logic [31:0]       perf_cycles, perf_stalls;
`endif

    int checks = 0;
    int errors = 0;

    matmul_loop_sequencer #(.IDX_W(IDX_W), .N_MAX(N_MAX), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dim_n    (dim_n),
        .busy     (busy),
        .done     (done),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .idx_i    (idx_i),
        .idx_j    (idx_j),
        .idx_k    (idx_k),
        .addr_a   (addr_a),
        .addr_b   (addr_b),
        .addr_c   (addr_c),
        .acc_clr  (acc_clr),
        .acc_wr   (acc_wr)
`ifdef MATMUL_SEQ_PERF_EN
        ,
        .perf_cycles (perf_cycles),
        .perf_stalls (perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Everything the sequencer drives must be 0 while idle.
    task automatic check_quiet(input string tag);
        check({tag, "_busy"},     32'(busy),     32'd0);
        check({tag, "_done"},     32'(done),     32'd0);
        check({tag, "_op_valid"}, 32'(op_valid), 32'd0);
        check({tag, "_idx_i"},    32'(idx_i),    32'd0);
        check({tag, "_idx_j"},    32'(idx_j),    32'd0);
        check({tag, "_idx_k"},    32'(idx_k),    32'd0);
        check({tag, "_addr_a"},   32'(addr_a),   32'd0);
        check({tag, "_addr_b"},   32'(addr_b),   32'd0);
        check({tag, "_addr_c"},   32'(addr_c),   32'd0);
        check({tag, "_acc_clr"},  32'(acc_clr),  32'd0);
        check({tag, "_acc_wr"},   32'(acc_wr),   32'd0);
    endtask

    // One run. ready_mode: 0 always ready, 1 ready on odd cycles only, 2 random.
    // poke drives random start/dim_n while busy; abort_at >= 0 resets after that many transfers.
    task automatic do_run(input int dim, input int ready_mode, input bit poke, input int abort_at);
        int  n, total, p, cycles, stalls, budget;
        int  ei, ej, ek;
        bit  rdy;
        n      = (dim > N_MAX) ? N_MAX : dim;
        total  = n * n * n;
        p      = 0;
        cycles = 0;
        stalls = 0;
        budget = 4 * total + 50;
        dim_n  = 4'(dim);
        start  = 1'b1;
        step();
        start  = 1'b0;
        while (1) begin
            if (abort_at >= 0 && p == abort_at) begin
                rst      = 1'b0;
                op_ready = 1'($urandom);
                step();
                rst      = 1'b1;
                op_ready = 1'b0;
                check_quiet("abort");
                step();
                check_quiet("abort_idle");
                return;
            end
            if (p < total) begin
                ei = p / (n * n);
                ej = (p / n) % n;
                ek = p % n;
                check("run_op_valid", 32'(op_valid), 32'd1);
                check("run_busy",     32'(busy),     32'd1);
                check("run_done",     32'(done),     32'd0);
                check("run_idx_i",    32'(idx_i),    32'(ei));
                check("run_idx_j",    32'(idx_j),    32'(ej));
                check("run_idx_k",    32'(idx_k),    32'(ek));
                check("run_addr_a",   32'(addr_a),   32'(ei * N_MAX + ek));
                check("run_addr_b",   32'(addr_b),   32'(ek * N_MAX + ej));
                check("run_addr_c",   32'(addr_c),   32'(ei * N_MAX + ej));
                check("run_acc_clr",  32'(acc_clr),  32'(ek == 0));
                check("run_acc_wr",   32'(acc_wr),   32'(ek == n - 1));
                case (ready_mode)
                    0:       rdy = 1'b1;
                    1:       rdy = (cycles % 2) == 1;
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                op_ready = rdy;
                if (poke) begin
                    start = 1'($urandom_range(0, 1));
                    dim_n = 4'($urandom);
                end
                cycles++;
                if (!rdy) stalls++;
                step();
                if (rdy) p++;
                if (cycles > budget) begin
                    check("run_timeout_cycles", 32'(cycles), 32'(budget));
                    start = 1'b0;
                    return;
                end
            end else begin
                check("fin_done",     32'(done),     32'd1);
                check("fin_busy",     32'(busy),     32'd1);
                check("fin_op_valid", 32'(op_valid), 32'd0);
                check("fin_idx_sum",  32'(idx_i) + 32'(idx_j) + 32'(idx_k), 32'd0);
                check("fin_addr_sum", 32'(addr_a) + 32'(addr_b) + 32'(addr_c), 32'd0);
                check("fin_acc",      32'(acc_clr) + 32'(acc_wr), 32'd0);
`ifdef MATMUL_SEQ_PERF_EN
                check("fin_perf_cycles", perf_cycles, 32'(cycles));
                check("fin_perf_stalls", perf_stalls, 32'(stalls));
`endif
                op_ready = 1'($urandom);
                if (poke) begin
                    start = 1'b1;
                    dim_n = 4'($urandom);
                end
                step();
                start = 1'b0;
                check_quiet("post");
`ifdef MATMUL_SEQ_PERF_EN
                check("post_perf_cycles", perf_cycles, 32'(cycles));
                check("post_perf_stalls", perf_stalls, 32'(stalls));
`endif
                step();
                check("idle_done",     32'(done),     32'd0);
                check("idle_op_valid", 32'(op_valid), 32'd0);
                return;
            end
        end
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        op_ready = 1'b0;
        dim_n    = '0;
        step();
        start    = 1'b1;
        dim_n    = 4'd3;
        step();
        check_quiet("reset");
`ifdef MATMUL_SEQ_PERF_EN
        check("reset_perf_cycles", perf_cycles, 32'd0);
        check("reset_perf_stalls", perf_stalls, 32'd0);
`endif
        start = 1'b0;
        rst   = 1'b1;
        step();
        check_quiet("idle_after_reset");

        do_run(2, 0, 1'b0, -1);
        do_run(0, 0, 1'b0, -1);
        do_run(3, 1, 1'b0, -1);
        do_run(3, 2, 1'b1, -1);
        do_run(1, 2, 1'b1, -1);
        do_run(3, 0, 1'b0, 5);
        do_run(3, 2, 1'b0, -1);
        do_run(15, 0, 1'b0, -1);
        for (int r = 0; r < 6; r++) begin
            do_run(int'($urandom_range(0, 15)), 2, 1'($urandom_range(0, 1)), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
